// File: rtl/iomem_led_pwm_pkg.sv
// Shared constants for the iomem LED PWM block: register map, CTRL bit
// positions and datapath widths used by the register file and the timebase.
package iomem_led_pwm_pkg;

  // Datapath widths
  localparam int DUTY_W     = 8;
  localparam int PRESCALE_W = 16;
  localparam int PWM_CNT_W  = 8;
  localparam int MAX_LEDS   = 8;

  // Register offsets, expressed as word index iomem_addr[4:2]
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_DUTY_LO  = 3'd2;
  localparam logic [2:0] OFF_DUTY_HI  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  // CTRL register bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_PEND   = 2;

  // Extract byte lane 'lane' (0..3) of a 32-bit bus word
  function automatic logic [7:0] laneByte(input logic [31:0] data, input int lane);
    return data[8*lane +: 8];
  endfunction

endpackage

// File: rtl/iomem_led_pwm_timebase.sv
// PWM timebase: a prescaler that divides the clock into ticks and an 8-bit
// PWM step counter advanced by each tick. The counter wrapping from 255 to 0
// marks the end of a PWM period. Both counters are held at zero while
// disabled.
module pwm_timebase
  import iomem_led_pwm_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick,
  output logic [PWM_CNT_W-1:0]  pwm_cnt,
  output logic                  period_end
);

  logic [PRESCALE_W-1:0] r_preCnt;
  logic [PWM_CNT_W-1:0]  r_pwmCnt;

  // A ">=" compare rather than "==" means a prescale value lowered below the
  // running count still produces a tick on the very next cycle.
  assign tick       = en && (r_preCnt >= prescale);
  assign period_end = tick && (r_pwmCnt == {PWM_CNT_W{1'b1}});
  assign pwm_cnt    = r_pwmCnt;

  // Prescaler and PWM step counter; both restart from zero whenever disabled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_preCnt <= '0;
      r_pwmCnt <= '0;
    end else if (!en) begin
      r_preCnt <= '0;
      r_pwmCnt <= '0;
    end else if (tick) begin
      r_preCnt <= '0;
      r_pwmCnt <= r_pwmCnt + 1'b1;
    end else begin
      r_preCnt <= r_preCnt + 1'b1;
    end
  end

endmodule

// File: rtl/iomem_led_pwm.sv
// iomem-mapped LED PWM controller. Decodes one 16 MB window of the SoC iomem
// bus, holds the CTRL/PRESCALE/duty register file, double-buffers duty values
// so they only change on PWM period boundaries, and drives registered
// active-high LED outputs plus a level interrupt on period end.
module iomem_led_pwm
  import iomem_led_pwm_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h03,
  parameter int         NUM_LEDS  = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  output logic [NUM_LEDS-1:0] leds,
  output logic                irq
);

  // Bus decode
  logic       w_sel;
  logic       w_write;
  logic [2:0] w_offset;
  logic       w_wrCtrl;
  logic       w_wrPrescale;
  logic       w_wrDutyLo;
  logic       w_wrDutyHi;

  // Bus response
  logic        r_ready;
  logic [31:0] r_rdata;
  logic [31:0] w_rdVal;

  // Control / status
  logic r_en;
  logic r_irqEn;
  logic r_pend;
  logic r_irq;
  logic w_enNext;
  logic w_irqEnNext;
  logic w_pendClr;
  logic w_pendNext;

  // Prescale and duty storage
  logic [PRESCALE_W-1:0]           r_prescale;
  logic [MAX_LEDS-1:0][DUTY_W-1:0] r_shadow;
  logic [MAX_LEDS-1:0][DUTY_W-1:0] r_active;
  logic [NUM_LEDS-1:0]             r_leds;

  // Timebase
  logic                 w_tick;
  logic                 w_periodEnd;
  logic [PWM_CNT_W-1:0] w_pwmCnt;

  // Address bits outside the decoded window plus the raw tick are not needed here
  logic w_unusedBits;
  assign w_unusedBits = ^{iomem_addr[23:5], iomem_addr[1:0], w_tick};

  // Masking with r_ready keeps a held request from being taken twice
  assign w_sel        = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE_ADDR);
  assign w_write      = w_sel && (iomem_wstrb != 4'b0000);
  assign w_offset     = iomem_addr[4:2];
  assign w_wrCtrl     = w_write && (w_offset == OFF_CTRL);
  assign w_wrPrescale = w_write && (w_offset == OFF_PRESCALE);
  assign w_wrDutyLo   = w_write && (w_offset == OFF_DUTY_LO);
  assign w_wrDutyHi   = w_write && (w_offset == OFF_DUTY_HI);

  pwm_timebase u_timebase (
    .clk        (clk),
    .resetn     (resetn),
    .en         (r_en),
    .prescale   (r_prescale),
    .tick       (w_tick),
    .pwm_cnt    (w_pwmCnt),
    .period_end (w_periodEnd)
  );

  // Read mux: returns the register contents as they were before any write in this cycle
  always_comb begin
    w_rdVal = '0;
    case (w_offset)
      OFF_CTRL: begin
        w_rdVal[CTRL_EN]     = r_en;
        w_rdVal[CTRL_IRQ_EN] = r_irqEn;
        w_rdVal[CTRL_PEND]   = r_pend;
      end
      OFF_PRESCALE: w_rdVal[PRESCALE_W-1:0] = r_prescale;
      OFF_DUTY_LO:  w_rdVal = r_shadow[3:0];
      OFF_DUTY_HI:  w_rdVal = r_shadow[7:4];
      OFF_STATUS:   w_rdVal[PWM_CNT_W-1:0] = w_pwmCnt;
      default:      w_rdVal = '0;
    endcase
  end

  // Single-cycle ready pulse and captured read data for each selected access
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_sel;
      r_rdata <= w_sel ? w_rdVal : '0;
    end
  end

  // Next CTRL state; a period end setting PEND overrides a same-cycle clear
  always_comb begin
    w_enNext    = r_en;
    w_irqEnNext = r_irqEn;
    w_pendClr   = 1'b0;
    w_pendNext  = r_pend;
    if (w_wrCtrl && iomem_wstrb[0]) begin
      w_enNext    = iomem_wdata[CTRL_EN];
      w_irqEnNext = iomem_wdata[CTRL_IRQ_EN];
      w_pendClr   = iomem_wdata[CTRL_PEND];
    end
    if (w_pendClr) begin
      w_pendNext = 1'b0;
    end
    if (w_periodEnd) begin
      w_pendNext = 1'b1;
    end
  end

  // CTRL register and interrupt; irq is built from next-state so it tracks PEND exactly
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_en    <= 1'b0;
      r_irqEn <= 1'b0;
      r_pend  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_en    <= w_enNext;
      r_irqEn <= w_irqEnNext;
      r_pend  <= w_pendNext;
      r_irq   <= w_pendNext && w_irqEnNext;
    end
  end

  // PRESCALE register, written per byte lane in its low half
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prescale <= '0;
    end else begin
      for (int i = 0; i < PRESCALE_W / 8; i++) begin
        if (w_wrPrescale && iomem_wstrb[i]) begin
          r_prescale[8*i +: 8] <= laneByte(iomem_wdata, i);
        end
      end
    end
  end

  // Shadow duty bytes; bytes for LEDs that do not exist are never written and stay 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shadow <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wrDutyLo && iomem_wstrb[i] && (i < NUM_LEDS)) begin
          r_shadow[i] <= laneByte(iomem_wdata, i);
        end
        if (w_wrDutyHi && iomem_wstrb[i] && ((i + 4) < NUM_LEDS)) begin
          r_shadow[i+4] <= laneByte(iomem_wdata, i);
        end
      end
    end
  end

  // Active duties follow the shadow freely while stopped, otherwise only at period end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_active <= '0;
    end else if (!r_en || w_periodEnd) begin
      r_active <= r_shadow;
    end
  end

  // PWM compare: an LED is on for the first 'duty' steps of each 256-step period
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_leds <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_leds[i] <= r_en && (w_pwmCnt < r_active[i]);
      end
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign leds        = r_leds;
  assign irq         = r_irq;

endmodule

// File: tb/tb_iomem_led_pwm.sv
// Testbench for iomem_led_pwm: directed bus accesses push their expected read
// data into a scoreboard queue; a monitor pops and compares on every ready.
// LED, interrupt and timing behaviour is checked against hand-derived counts.
module tb_iomem_led_pwm;

  localparam logic [31:0] A_CTRL     = 32'h0300_0000;
  localparam logic [31:0] A_PRESCALE = 32'h0300_0004;
  localparam logic [31:0] A_DUTY_LO  = 32'h0300_0008;
  localparam logic [31:0] A_DUTY_HI  = 32'h0300_000C;
  localparam logic [31:0] A_STATUS   = 32'h0300_0010;
  localparam logic [31:0] A_UNMAPPED = 32'h0300_0014;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [7:0]  leds;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // Scoreboard: bit 32 says whether the data must be compared
  logic [32:0] expQ[$];
  string       nameQ[$];
  logic        prevReady = 1'b0;

  int hi0, hi1, f0, f1, f2, n;
  int ledCnt[8];
  bit sawReady;

  iomem_led_pwm #(
    .BASE_ADDR (8'h03),
    .NUM_LEDS  (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .leds        (leds),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One bus access; expected read data goes to the scoreboard, latency is checked here
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input bit expReady,
                               input logic [31:0] expData, input bit chk, input string name);
    int  lat;
    bit  seen;
    if (expReady) begin
      expQ.push_back({chk, expData});
      nameQ.push_back(name);
    end
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wdata = wdata;
    iomem_wstrb = wstrb;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      seen = iomem_ready;
    end
    checks++;
    if (expReady ? (!seen || lat != 1) : seen) begin
      errors++;
      $display("[TB] FAIL %s_readyLatency: ready seen=%0d after %0d cycles, expected seen=%0d after 1",
               name, seen, lat, expReady);
    end
    @(negedge clk);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
  endtask

  // Monitor: compare read data whenever the DUT completes an access
  always @(negedge clk) begin
    if (resetn && iomem_ready) begin
      if (prevReady) begin
        checks++;
        errors++;
        $display("[TB] FAIL readyWidth: ready high for 2 cycles, expected 1");
      end
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedReady: ready with empty scoreboard, rdata 0x%0h", iomem_rdata);
      end else begin
        logic [32:0] e;
        string       nm;
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        if (e[32]) checkOutput(nm, iomem_rdata, e[31:0]);
      end
    end
    prevReady = resetn && iomem_ready;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("resetReady", {31'b0, iomem_ready}, 32'h0);
    checkOutput("resetRdata", iomem_rdata, 32'h0);
    checkOutput("resetLeds", {24'b0, leds}, 32'h0);
    checkOutput("resetIrq", {31'b0, irq}, 32'h0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Bus basics, byte lanes, unmapped offsets and reserved bits
    applyStimulus(A_PRESCALE, 32'h0000_0003, 4'hF, 1, 32'h0, 1, "wrPrescale");
    applyStimulus(A_PRESCALE, 32'h0, 4'h0, 1, 32'h3, 1, "rdPrescale");
    applyStimulus(32'h0200_0004, 32'h0, 4'h0, 0, 32'h0, 0, "otherBase");
    applyStimulus(A_PRESCALE, 32'hAABB_CCDD, 4'b0010, 1, 32'h3, 1, "wrPrescaleLane1");
    applyStimulus(A_PRESCALE, 32'h0, 4'h0, 1, 32'h0000_CC03, 1, "rdPrescaleLane1");
    applyStimulus(A_UNMAPPED, 32'hFFFF_FFFF, 4'hF, 1, 32'h0, 1, "wrUnmapped");
    applyStimulus(A_UNMAPPED, 32'h0, 4'h0, 1, 32'h0, 1, "rdUnmapped");
    applyStimulus(A_CTRL, 32'hFFFF_FFF8, 4'hF, 1, 32'h0, 1, "wrCtrlRsvd");
    applyStimulus(A_CTRL, 32'h0, 4'h0, 1, 32'h0, 1, "rdCtrlRsvd");
    applyStimulus(A_DUTY_HI, 32'h1122_3344, 4'hF, 1, 32'h0, 1, "wrDutyHi");
    applyStimulus(A_DUTY_HI, 32'h0, 4'h0, 1, 32'h1122_3344, 1, "rdDutyHi");
    applyStimulus(A_STATUS, 32'hFF, 4'hF, 1, 32'h0, 1, "wrStatus");
    applyStimulus(A_STATUS, 32'h0, 4'h0, 1, 32'h0, 1, "rdStatusIdle");

    // Duty ratios over one full period at PRESCALE=0
    applyStimulus(A_PRESCALE, 32'h0, 4'hF, 1, 32'h0000_CC03, 1, "wrPrescale0");
    applyStimulus(A_DUTY_LO, 32'hFF80_4000, 4'hF, 1, 32'h0, 1, "wrDutyLo");
    applyStimulus(A_DUTY_HI, 32'h0, 4'hF, 1, 32'h1122_3344, 1, "clrDutyHi");
    applyStimulus(A_CTRL, 32'h1, 4'hF, 1, 32'h0, 1, "enDuty");
    foreach (ledCnt[i]) ledCnt[i] = 0;
    repeat (4) @(posedge clk);
    for (int c = 0; c < 256; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) ledCnt[i] += int'(leds[i]);
    end
    checkOutput("led0High", ledCnt[0], 0);
    checkOutput("led1High", ledCnt[1], 64);
    checkOutput("led2High", ledCnt[2], 128);
    checkOutput("led3High", ledCnt[3], 255);
    checkOutput("led4to7High", ledCnt[4] + ledCnt[5] + ledCnt[6] + ledCnt[7], 0);
    applyStimulus(A_CTRL, 32'h4, 4'hF, 1, 32'h5, 1, "disDuty");
    @(posedge clk);
    #1;
    checkOutput("ledsOffAfterDisable", {24'b0, leds}, 32'h0);

    // Shadowing: a mid-period duty change only takes effect next period
    applyStimulus(A_DUTY_LO, 32'h40, 4'hF, 1, 32'hFF80_4000, 1, "wrDuty40");
    applyStimulus(A_CTRL, 32'h1, 4'hF, 1, 32'h0, 1, "enShadow");
    hi0 = 0;
    hi1 = 0;
    fork
      begin
        for (int k = 1; k <= 512; k++) begin
          @(posedge clk);
          #1;
          if (k <= 256) hi0 += int'(leds[0]);
          else          hi1 += int'(leds[0]);
        end
      end
      begin
        repeat (100) @(posedge clk);
        applyStimulus(A_DUTY_LO, 32'hC0, 4'b0001, 1, 32'h40, 1, "wrDutyMid");
      end
    join
    checkOutput("shadowCurPeriod", hi0, 64);
    checkOutput("shadowNextPeriod", hi1, 192);
    applyStimulus(A_CTRL, 32'h4, 4'hF, 1, 32'h5, 1, "disShadow");

    // Interrupt timing and set-wins-over-clear on period end
    applyStimulus(A_PRESCALE, 32'h1, 4'hF, 1, 32'h0, 1, "wrPrescale1");
    applyStimulus(A_CTRL, 32'h3, 4'hF, 1, 32'h0, 1, "enIrq");
    n = 0;
    while (!irq && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("irqRiseCycle", n, 512);
    applyStimulus(A_CTRL, 32'h7, 4'hF, 1, 32'h7, 1, "clrPend");
    checkOutput("irqAfterClear", {31'b0, irq}, 32'h0);
    repeat (510) @(posedge clk);
    applyStimulus(A_CTRL, 32'h7, 4'hF, 1, 32'h3, 1, "clrAtPeriodEnd");
    applyStimulus(A_CTRL, 32'h0, 4'h0, 1, 32'h7, 1, "pendSetWins");
    checkOutput("irqSetWins", {31'b0, irq}, 32'h1);
    applyStimulus(A_CTRL, 32'h4, 4'hF, 1, 32'h7, 1, "disIrq");

    // Prescale shrink below the running count: tick next cycle, then every 11
    applyStimulus(A_PRESCALE, 32'd1000, 4'hF, 1, 32'h1, 1, "wrPrescale1000");
    applyStimulus(A_DUTY_LO, 32'h0003_0201, 4'hF, 1, 32'h0000_00C0, 1, "wrDutySteps");
    applyStimulus(A_CTRL, 32'h1, 4'hF, 1, 32'h0, 1, "enShrink");
    f0 = 0;
    f1 = 0;
    f2 = 0;
    fork
      begin
        for (int k = 1; k <= 700; k++) begin
          @(posedge clk);
          #1;
          if (!leds[0] && f0 == 0) f0 = k;
          if (!leds[1] && f1 == 0) f1 = k;
          if (!leds[2] && f2 == 0) f2 = k;
        end
      end
      begin
        repeat (600) @(posedge clk);
        applyStimulus(A_PRESCALE, 32'd10, 4'hF, 1, 32'd1000, 1, "wrPrescale10");
      end
    join
    checkOutput("shrinkTick1", f0, 603);
    checkOutput("shrinkTick2", f1, 614);
    checkOutput("shrinkTick3", f2, 625);
    applyStimulus(A_CTRL, 32'h4, 4'hF, 1, 32'h1, 1, "disShrink");

    // Reset in the middle of a read
    applyStimulus(A_PRESCALE, 32'h0, 4'hF, 1, 32'd10, 1, "wrPrescaleR");
    applyStimulus(A_DUTY_LO, 32'hFF, 4'hF, 1, 32'h0003_0201, 1, "wrDutyFF");
    applyStimulus(A_CTRL, 32'h3, 4'hF, 1, 32'h0, 1, "enReset");
    repeat (341) @(posedge clk);
    applyStimulus(A_STATUS, 32'h0, 4'h0, 1, 32'h55, 1, "rdStatus55");
    checkOutput("preResetIrq", {31'b0, irq}, 32'h1);
    checkOutput("preResetLeds", {24'b0, leds}, 32'h1);
    iomem_valid = 1'b1;
    iomem_addr  = A_STATUS;
    iomem_wstrb = 4'b0000;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midResetReady", {31'b0, iomem_ready}, 32'h0);
    checkOutput("midResetLeds", {24'b0, leds}, 32'h0);
    checkOutput("midResetIrq", {31'b0, irq}, 32'h0);
    checkOutput("midResetRdata", iomem_rdata, 32'h0);
    @(negedge clk);
    iomem_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    sawReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (iomem_ready) sawReady = 1'b1;
    end
    checkOutput("postResetNoReady", {31'b0, sawReady}, 32'h0);
    checkOutput("postResetLeds", {24'b0, leds}, 32'h0);
    checkOutput("postResetIrq", {31'b0, irq}, 32'h0);
    applyStimulus(A_STATUS, 32'h0, 4'h0, 1, 32'h0, 1, "rdStatusAfterReset");
    applyStimulus(A_CTRL, 32'h0, 4'h0, 1, 32'h0, 1, "rdCtrlAfterReset");
    applyStimulus(A_DUTY_LO, 32'h0, 4'h0, 1, 32'h0, 1, "rdDutyAfterReset");

    repeat (2) @(negedge clk);
    checkOutput("scoreboardDrain", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
